dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter bits, default 32, meaning the data and address word width.
REQ-002 SHALL have parameter addr_width_DMEM, default 10, meaning memory size = 2**addr_width_DMEM bytes.
REQ-003 SHALL have parameter wait_cycles, default 1, meaning the number of wait states per access (0..15).
REQ-004 SHALL have port: clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port: async_reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port: req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port: req_ready  output  1  responder accepts a request this cycle.
REQ-008 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port: req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 SHALL have port: req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-011 SHALL have port: req_addr  input  bits  byte address.
REQ-012 SHALL have port: req_wdata  input  bits  store data, right-aligned.
REQ-013 SHALL have port: rsp_valid  output  1  response available.
REQ-014 SHALL have port: rsp_ready  input  1  initiator accepts the response.
REQ-015 SHALL have port: rsp_rdata  output  bits  load result, extended; 0 for stores and errors.
REQ-016 SHALL have port: rsp_err  output  1  request was misaligned, out of range or had an illegal size.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 In IDLE, SHALL drive req_ready=1; all other states SHALL drive req_ready=0.
REQ-019 SHALL accept a request (handshake) when req_valid and req_ready are both 1, latching all req_* fields, loading the wait counter with wait_cycles and entering WAIT.
REQ-020 In WAIT, SHALL decrement the counter each cycle; in the cycle the counter equals 0 it SHALL perform the access and enter RESP.
REQ-021 Latency: for a handshake at edge N, rsp_valid SHALL first be 1 after edge N+1+wait_cycles.
REQ-022 In RESP, SHALL hold rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE on that edge.
REQ-023 No new request SHALL be accepted in the cycle a response retires; the next request is accepted one cycle later, from IDLE.
REQ-024 Error conditions: half with addr[0]=1; word with addr[1:0]!=0; req_size=11; addr >= 2**addr_width_DMEM.
REQ-025 On error, SHALL perform no memory write, return rsp_err=1 and rsp_rdata=0, with unchanged latency.
REQ-026 Stores SHALL write only the addressed byte lanes (little-endian) with the low 8/16/32 bits of req_wdata.
REQ-027 Loads SHALL extract the addressed lanes and sign- or zero-extend them to bits per req_unsigned.
REQ-028 Memory SHALL be word-organised, 2**(addr_width_DMEM-2) entries, indexed by addr[addr_width_DMEM-1:2].
REQ-029 A load SHALL return the memory contents as they stand after all earlier accepted stores.

Reset
REQ-030 While async_reset_n=0 at a clk edge: state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-031 req_ready SHALL be 0 while async_reset_n=0 and 1 in the first cycle after release.
REQ-032 Reset in WAIT before the access cycle SHALL abort the transaction with no memory write; reset in RESP SHALL drop the pending response.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-034 A shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state type and the wait-counter width.
REQ-035 Lane extraction, extension and byte-enable generation SHALL be one sub-module, dmem_lane_align, which is purely combinational.

Verification
REQ-036 Word store 0xDEADBEEF to address 0x10, then a word load from 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after each handshake (wait_cycles=1).
REQ-037 Signed byte load from 0x13 -> 0xFFFFFFDE; unsigned half load from 0x12 -> 0x0000DEAD.
REQ-038 Byte store 0x55 to 0x11, then a word load from 0x10 -> 0xDEAD55EF.
REQ-039 Word store to 0x12 -> rsp_err=1; a following word load from 0x10 -> unchanged data. Load from 0x400 (addr_width_DMEM=10) -> rsp_err=1, rsp_rdata=0.
REQ-040 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; on release -> IDLE, and the next request is accepted one cycle later.
REQ-041 Store accepted, then async_reset_n=0 during WAIT -> rsp_valid=0, and a subsequent load returns the old data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and alignment helper for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Flags misaligned halves/words; the reserved size encoding always faults.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and alignment, load extraction and extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int bits = 32
) (
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [1:0]      addr_lo,
  input  logic [bits-1:0] wdata,
  input  logic [bits-1:0] word,
  output logic [3:0]      be,
  output logic [bits-1:0] wdata_lane,
  output logic [bits-1:0] rdata_ext
);

  logic [4:0]      shamt_s;
  logic [bits-1:0] shifted_s;

  assign shamt_s    = {addr_lo, 3'b000};
  assign shifted_s  = word >> shamt_s;
  assign wdata_lane = wdata << shamt_s;

  // Select lanes for the access size and sign/zero-extend the loaded value.
  always_comb begin
    be        = 4'b0000;
    rdata_ext = {bits{1'b0}};
    case (size)
      SZ_BYTE: begin
        be = 4'b0001 << addr_lo;
        if (is_unsigned) begin
          rdata_ext = {{(bits-8){1'b0}}, shifted_s[7:0]};
        end else begin
          rdata_ext = {{(bits-8){shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      SZ_HALF: begin
        be = 4'b0011 << addr_lo;
        if (is_unsigned) begin
          rdata_ext = {{(bits-16){1'b0}}, shifted_s[15:0]};
        end else begin
          rdata_ext = {{(bits-16){shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      SZ_WORD: begin
        be        = 4'b1111;
        rdata_ext = shifted_s;
      end
      default: begin
        be        = 4'b0000;
        rdata_ext = {bits{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states and fault reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int bits            = 32,
  parameter int addr_width_DMEM = 10,
  parameter int wait_cycles     = 1
) (
  input  logic            clk,
  input  logic            async_reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [bits-1:0] req_addr,
  input  logic [bits-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [bits-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int DEPTH = 2 ** (addr_width_DMEM - 2);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic             rsp_err_r;
  logic [bits-1:0]  rsp_rdata_r;

  logic             we_r;
  logic [1:0]       size_r;
  logic             uns_r;
  logic [bits-1:0]  addr_r;
  logic [bits-1:0]  wdata_r;

  logic [bits-1:0]  mem_r [0:DEPTH-1];

  logic [addr_width_DMEM-3:0] idx_s;
  logic             range_err_s;
  logic             err_s;
  logic             access_s;
  logic             mem_we_s;
  logic [bits-1:0]  word_s;
  logic [3:0]       be_s;
  logic [bits-1:0]  wlane_s;
  logic [bits-1:0]  rdata_ext_s;

  assign idx_s       = addr_r[addr_width_DMEM-1:2];
  assign range_err_s = ((addr_r >> addr_width_DMEM) != {bits{1'b0}});
  assign err_s       = range_err_s | misaligned(size_r, addr_r[1:0]);
  assign access_s    = (state_r == WAIT) && (cnt_r == {CNT_W{1'b0}});
  // Reset gates the write so an aborted transaction never touches memory.
  assign mem_we_s    = async_reset_n && access_s && we_r && !err_s;
  assign word_s      = mem_r[idx_s];

  dmem_lane_align #(.bits(bits)) u_lane (
    .size        (size_r),
    .is_unsigned (uns_r),
    .addr_lo     (addr_r[1:0]),
    .wdata       (wdata_r),
    .word        (word_s),
    .be          (be_s),
    .wdata_lane  (wlane_s),
    .rdata_ext   (rdata_ext_s)
  );

  // Request/wait/response sequencing with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!async_reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {bits{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            we_r        <= req_we;
            size_r      <= req_size;
            uns_r       <= req_unsigned;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            cnt_r       <= CNT_W'(wait_cycles);
            req_ready_r <= 1'b0;
            state_r     <= WAIT;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s || we_r) ? {bits{1'b0}} : rdata_ext_s;
            state_r     <= RESP;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          // Retiring lands in IDLE with ready set, so the next accept is one cycle later.
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {bits{1'b0}};
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane writes; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule
